// File: rtl/dmux_ctrl.sv
// dmux_ctrl: frame parser driving a 4-way demux (header + N payload words).
// Optional build macro: DMUX_CTRL_ERRCNT_EN enables the saturating err_cnt.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_data, in_valid upstream word and its valid strobe
//   hold              downstream stall; in_ready = ~hold
//   in_ready          word accepted when in_valid & in_ready
//   sel, data_out     demux select and registered payload word
//   out_valid         data_out/sel carry a payload word
//   frame_done        pulse on the last payload word of a frame
//   err, err_cnt      sticky channel-3 flag and errored-frame count
module dmux_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        hold,
    output logic        in_ready,
    output logic [1:0]  sel,
    output logic [15:0] data_out,
    output logic        out_valid,
    output logic        frame_done,
    output logic        err,
    output logic [7:0]  err_cnt
);

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] hdr_len;
    logic [1:0]       sel_n;
    logic [15:0]      data_n;
    logic             ov_n, fd_n, err_n;
    logic             acc, hdr_ch3;

    assign in_ready = ~hold;
    assign acc      = in_valid & ~hold;
    assign hdr_len  = in_data[LEN_W+1:2];
    assign hdr_ch3  = acc & (state == IDLE) & (in_data[1:0] == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 2'd0;
            data_out   <= 16'h0000;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            data_out   <= data_n;
            out_valid  <= ov_n;
            frame_done <= fd_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        data_n  = 16'h0000;
        ov_n    = 1'b0;
        fd_n    = 1'b0;
        err_n   = err | hdr_ch3;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    sel_n = in_data[1:0];
                    cnt_n = hdr_len;
                    // Zero-length frames never leave IDLE.
                    if (hdr_len != '0)
                        state_n = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (acc) begin
                    cnt_n = cnt - 1'b1;
                    fd_n  = (cnt == LEN_W'(1));
                    // Channel 3 frames are consumed but dropped.
                    if (sel != 2'd3) begin
                        ov_n   = 1'b1;
                        data_n = in_data;
                    end
                    if (cnt == LEN_W'(1))
                        state_n = IDLE;
                end
            end
        endcase
    end

`ifdef DMUX_CTRL_ERRCNT_EN
    logic [7:0] ecnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ecnt <= 8'h00;
        else if (hdr_ch3 && ecnt != 8'hFF)
            ecnt <= ecnt + 8'd1;
    end

    assign err_cnt = ecnt;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_dmux_ctrl.sv
// tb_dmux_ctrl: directed + randomized checks of dmux_ctrl
// against a frame-level reference model.
module tb_dmux_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_valid = 1'b0;
    logic        hold = 1'b0;
    logic        in_ready;
    logic [1:0]  sel;
    logic [15:0] data_out;
    logic        out_valid, frame_done, err;
    logic [7:0]  err_cnt;

    dmux_ctrl #(.LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data),
        .in_valid(in_valid), .hold(hold), .in_ready(in_ready),
        .sel(sel), .data_out(data_out), .out_valid(out_valid),
        .frame_done(frame_done), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: "is the next word a header", words left, channel.
    bit          m_hdr = 1'b1;
    int          m_left = 0;
    int          m_ch = 0;
    bit          m_ov = 1'b0, m_fd = 1'b0, m_err = 1'b0;
    logic [15:0] m_do = 16'h0;
    int          m_ecnt = 0;

    wire [28:0] act = {out_valid, data_out, sel, frame_done, err, err_cnt};

    function automatic logic [28:0] expv();
        return {m_ov, m_do, 2'(m_ch), m_fd, m_err, 8'(m_ecnt)};
    endfunction

    task automatic model_reset();
        m_hdr = 1'b1; m_left = 0; m_ch = 0;
        m_ov = 1'b0; m_fd = 1'b0; m_err = 1'b0;
        m_do = 16'h0; m_ecnt = 0;
    endtask

    task automatic model_step(input bit a, input logic [15:0] d);
        m_ov = 1'b0; m_fd = 1'b0; m_do = 16'h0;
        if (a) begin
            if (m_hdr) begin
                m_ch = int'(d[1:0]);
                m_left = (int'(d) >> 2) & 255;
                m_hdr = (m_left == 0);
                if (m_ch == 3) begin
                    m_err = 1'b1;
`ifdef DMUX_CTRL_ERRCNT_EN
                    if (m_ecnt < 255) m_ecnt++;
`endif
                end
            end else begin
                m_left--;
                m_fd = (m_left == 0);
                m_hdr = m_fd;
                if (m_ch != 3) begin
                    m_ov = 1'b1;
                    m_do = d;
                end
            end
        end
    endtask

    // Present one word for one clock; returns 1 time unit after the edge.
    task automatic drive(input bit v, input logic [15:0] d, input bit h);
        in_valid = v; in_data = d; hold = h;
        @(posedge clk);
        model_step(v & ~h, d);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hold = 1'b0;
        #1;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready0 act=%b exp=1", in_ready);
        end
        checks++;
        hold = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready1 act=%b exp=0", in_ready);
        end
        checks++;
        if (act !== 29'h0) begin
            errors++;
            $display("FAIL rst_outs act=%h exp=0", act);
        end
        checks++;
        hold = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] w [3] = '{16'h0009, 16'hAAAA, 16'h5555};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, w[i], 1'b0);
            if (act !== expv()) begin
                errors++;
                $display("FAIL basic[%0d] act=%h exp=%h", i, act, expv());
            end
            checks++;
        end
        if (!(out_valid && data_out == 16'h5555 && sel == 2'd1
              && frame_done)) begin
            errors++;
            $display("FAIL basic_last act=%h exp ov=1 5555 sel1 fd", act);
        end
        checks++;
        drive(1'b0, 16'h0, 1'b0);
        if (out_valid !== 1'b0 || data_out !== 16'h0) begin
            errors++;
            $display("FAIL basic_idle act=%h exp=0", act);
        end
        checks++;
    endtask

    task automatic test_zero_len_b2b();
        logic [15:0] w [3] = '{16'h0002, 16'h0004, 16'h1234};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, w[i], 1'b0);
            if (act !== expv()) begin
                errors++;
                $display("FAIL b2b[%0d] act=%h exp=%h", i, act, expv());
            end
            checks++;
            if (i == 0 && (out_valid || frame_done || sel != 2'd2)) begin
                errors++;
                $display("FAIL zero_len act=%h exp sel2 no output", act);
            end
            if (i == 0) checks++;
        end
        if (!(out_valid && data_out == 16'h1234 && sel == 2'd0
              && frame_done)) begin
            errors++;
            $display("FAIL b2b_last act=%h exp 1234 sel0 fd", act);
        end
        checks++;
    endtask

    task automatic test_ch3();
        drive(1'b1, 16'h0007, 1'b0);
        if (err !== 1'b1 || act !== expv()) begin
            errors++;
            $display("FAIL ch3_hdr act=%h exp=%h", act, expv());
        end
        checks++;
        drive(1'b1, 16'hBEEF, 1'b0);
        if (out_valid !== 1'b0 || data_out !== 16'h0
            || frame_done !== 1'b1 || act !== expv()) begin
            errors++;
            $display("FAIL ch3_drop act=%h exp=%h", act, expv());
        end
        checks++;
    endtask

    task automatic test_hold();
        drive(1'b1, 16'h000E, 1'b0);
        drive(1'b1, 16'h1111, 1'b0);
        if (act !== expv() || data_out !== 16'h1111) begin
            errors++;
            $display("FAIL hold_first act=%h exp=%h", act, expv());
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h2222, 1'b1);
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_stall[%0d] rdy=%b ov=%b exp 0 0",
                         i, in_ready, out_valid);
            end
            checks++;
        end
        drive(1'b1, 16'h2222, 1'b0);
        if (act !== expv() || data_out !== 16'h2222) begin
            errors++;
            $display("FAIL hold_w2 act=%h exp=%h", act, expv());
        end
        checks++;
        drive(1'b1, 16'h3333, 1'b0);
        if (act !== expv() || frame_done !== 1'b1
            || sel !== 2'd2) begin
            errors++;
            $display("FAIL hold_w3 act=%h exp=%h", act, expv());
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        drive(1'b1, 16'h0011, 1'b0);
        drive(1'b1, 16'hC0DE, 1'b0);
        drive(1'b1, 16'hCAFE, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        if (act !== 29'h0) begin
            errors++;
            $display("FAIL mid_rst act=%h exp=0", act);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h0008, 1'b0);
        if (out_valid !== 1'b0 || sel !== 2'd0) begin
            errors++;
            $display("FAIL post_rst_hdr act=%h exp hdr", act);
        end
        checks++;
        drive(1'b1, 16'h4444, 1'b0);
        drive(1'b1, 16'h5678, 1'b0);
        if (act !== expv() || data_out !== 16'h5678
            || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_pl act=%h exp=%h", act, expv());
        end
        checks++;
    endtask

    task automatic test_random();
        logic [15:0] d;
        bit v, h;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            h = ($urandom_range(0, 4) == 0);
            d = 16'($urandom);
            if (m_hdr) d[9:2] = 8'($urandom_range(0, 5));
            drive(v, d, h);
            if (act !== expv() || in_ready !== ~h) begin
                errors++;
                $display("FAIL rand[%0d] act=%h exp=%h rdy=%b",
                         i, act, expv(), in_ready);
            end
            checks++;
        end
    endtask

    task automatic test_err_sat();
        logic [7:0] want;
`ifdef DMUX_CTRL_ERRCNT_EN
        want = 8'hFF;
`else
        want = 8'h00;
`endif
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 16'h0003, 1'b0);
            if (i == 100 && act !== expv()) begin
                errors++;
                $display("FAIL sat_mid act=%h exp=%h", act, expv());
            end
            if (i == 100) checks++;
        end
        if (err_cnt !== want || err !== 1'b1) begin
            errors++;
            $display("FAIL err_sat act=%h exp=%h", err_cnt, want);
        end
        checks++;
        drive(1'b1, 16'h0003, 1'b0);
        if (err_cnt !== want) begin
            errors++;
            $display("FAIL err_hold act=%h exp=%h", err_cnt, want);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len_b2b();
        test_ch3();
        test_hold();
        test_reset_midframe();
        test_random();
        test_err_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
